// File: rtl/data_mem_wdata_unit.sv
// Data-memory write-data source: operand / PC / PC-history / flag mux plus a 2-beat
// interrupt context-save sequencer. Optional even parity output under DMEM_WDATA_PARITY_EN.

module data_mem_wdata_hist_stage #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_q <= '0;
        else if (i_en)  r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module data_mem_wdata_unit #(
    parameter int DW         = 8,
    parameter int HIST_DEPTH = 2,
    parameter int HIW        = 1,
    parameter int CCR_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_sel,
    input  logic [HIW-1:0]   i_hist_idx,
    input  logic [DW-1:0]    i_rb,
    input  logic [DW-1:0]    i_next_pc,
    input  logic             i_pc_hold,
    input  logic [CCR_W-1:0] i_ccr,
    input  logic             i_save_req,
    output logic [DW-1:0]    o_data_in,
    output logic             o_save_we,
    output logic             o_save_busy,
    output logic             o_save_done
`ifdef DMEM_WDATA_PARITY_EN
    ,
    output logic             o_data_par
`endif
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SAVE_PC  = 2'd1,
        S_SAVE_CCR = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0]    ret_pc;
        logic [CCR_W-1:0] ccr_snap;
    } save_ctx_t;

    logic [HIST_DEPTH-1:0][DW-1:0] w_hist;
    logic [DW-1:0]                 w_hist_sel;
    logic [DW-1:0]                 w_mux;
    state_t                        r_state;
    state_t                        w_state_nxt;
    save_ctx_t                     r_ctx;

    // History pipeline: one register per stage, all sharing the stall enable.
    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
        logic [DW-1:0] w_d;
        if (g == 0) begin : g_head
            assign w_d = i_next_pc;
        end else begin : g_tail
            assign w_d = w_hist[g-1];
        end
        data_mem_wdata_hist_stage #(.DW(DW)) u_stage (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (!i_pc_hold),
            .i_d   (w_d),
            .o_q   (w_hist[g])
        );
    end

    // Out-of-range indices clamp to the oldest stage.
    always_comb begin
        w_hist_sel = w_hist[HIST_DEPTH-1];
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (32'(i_hist_idx) == 32'(i)) w_hist_sel = w_hist[i];
        end
    end

    always_comb begin
        w_mux = i_rb;
        case (i_sel)
            2'b00:   w_mux = i_rb;
            2'b01:   w_mux = i_next_pc;
            2'b10:   w_mux = w_hist_sel;
            default: w_mux = DW'(i_ccr);
        endcase
    end

    // Snapshot is taken only on the accepting cycle so later input changes cannot leak in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ctx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_save_req) begin
                r_ctx.ret_pc   <= i_next_pc;
                r_ctx.ccr_snap <= i_ccr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_data_in   = w_mux;
        o_save_we   = 1'b0;
        o_save_busy = 1'b0;
        o_save_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_save_req) w_state_nxt = S_SAVE_PC;
            end
            S_SAVE_PC: begin
                o_data_in   = r_ctx.ret_pc;
                o_save_we   = 1'b1;
                o_save_busy = 1'b1;
                w_state_nxt = S_SAVE_CCR;
            end
            S_SAVE_CCR: begin
                o_data_in   = DW'(r_ctx.ccr_snap);
                o_save_we   = 1'b1;
                o_save_busy = 1'b1;
                o_save_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DMEM_WDATA_PARITY_EN
    assign o_data_par = ^o_data_in;
`endif
endmodule

// File: tb/tb_data_mem_wdata_unit.sv
// Directed bench for data_mem_wdata_unit: history, hold, mux, context save and reset abort.
// A second instance with a deeper history covers the index clamp.

module tb_data_mem_wdata_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic [0:0] hist_idx;
    logic [1:0] hist_idx2;
    logic [7:0] rb;
    logic [7:0] next_pc;
    logic       pc_hold;
    logic [3:0] ccr;
    logic       save_req;
    logic [7:0] data_in;
    logic       save_we, save_busy, save_done;
    logic [7:0] data_in2;
    logic       we2, busy2, done2;
`ifdef DMEM_WDATA_PARITY_EN
    logic       data_par, data_par2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_wdata_unit #(.DW(8), .HIST_DEPTH(2), .HIW(1), .CCR_W(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_hist_idx(hist_idx), .i_rb(rb),
        .i_next_pc(next_pc), .i_pc_hold(pc_hold), .i_ccr(ccr), .i_save_req(save_req),
        .o_data_in(data_in), .o_save_we(save_we), .o_save_busy(save_busy),
        .o_save_done(save_done)
`ifdef DMEM_WDATA_PARITY_EN
        , .o_data_par(data_par)
`endif
    );

    data_mem_wdata_unit #(.DW(8), .HIST_DEPTH(3), .HIW(2), .CCR_W(4)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_hist_idx(hist_idx2), .i_rb(rb),
        .i_next_pc(next_pc), .i_pc_hold(pc_hold), .i_ccr(ccr), .i_save_req(1'b0),
        .o_data_in(data_in2), .o_save_we(we2), .o_save_busy(busy2),
        .o_save_done(done2)
`ifdef DMEM_WDATA_PARITY_EN
        , .o_data_par(data_par2)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [7:0] exp);
        chk8(tag, data_in, exp);
`ifdef DMEM_WDATA_PARITY_EN
        chk1({tag, "_par"}, data_par, ^exp);
`endif
    endtask

    task automatic chk_flags(input string tag, input logic we, input logic busy, input logic done);
        chk1({tag, "_we"}, save_we, we);
        chk1({tag, "_busy"}, save_busy, busy);
        chk1({tag, "_done"}, save_done, done);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = 2'b10; hist_idx = 1'b0; hist_idx2 = 2'd0; rb = 8'hA5;
        next_pc = 8'h55; pc_hold = 1'b0; ccr = 4'h0; save_req = 1'b0;

        // 1: reset clears history and sequencer
        edge1(); edge1();
        #1;
        chk_data("rst_hist0", 8'h00);
        hist_idx = 1'b1; #1;
        chk_data("rst_hist1", 8'h00);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sel = 2'b00; #1;
        chk_data("mux_rb", 8'hA5);
        sel = 2'b11; ccr = 4'b1001; #1;
        chk_data("mux_ccr", 8'h09);

        // 2: history shift
        sel = 2'b10; next_pc = 8'h10; edge1();
        next_pc = 8'h11; edge1();
        next_pc = 8'h12; edge1();
        hist_idx = 1'b0; #1;
        chk_data("hist0", 8'h12);
        hist_idx = 1'b1; #1;
        chk_data("hist1", 8'h11);
        hist_idx2 = 2'd2; #1;
        chk8("d3_hist2", data_in2, 8'h10);
        hist_idx2 = 2'd3; #1;
        chk8("d3_clamp", data_in2, 8'h10);
        hist_idx2 = 2'd0; #1;
        chk8("d3_hist0", data_in2, 8'h12);

        // 3: stall freezes history, next_pc path still live
        pc_hold = 1'b1; next_pc = 8'h20; edge1();
        next_pc = 8'h21; edge1();
        hist_idx = 1'b0; #1;
        chk_data("hold_hist0", 8'h12);
        hist_idx = 1'b1; #1;
        chk_data("hold_hist1", 8'h11);
        sel = 2'b01; #1;
        chk_data("hold_npc", 8'h21);
        pc_hold = 1'b0;

        // 4: single context save with snapshot isolation
        sel = 2'b00; rb = 8'hA5; next_pc = 8'h3C; ccr = 4'b1010; save_req = 1'b1; #1;
        chk_data("sv_idle", 8'hA5);
        chk_flags("sv_idle", 1'b0, 1'b0, 1'b0);
        edge1();
        save_req = 1'b0; next_pc = 8'h44; ccr = 4'b0101; sel = 2'b01; #1;
        chk_data("sv_beat1", 8'h3C);
        chk_flags("sv_beat1", 1'b1, 1'b1, 1'b0);
        edge1();
        chk_data("sv_beat2", 8'h0A);
        chk_flags("sv_beat2", 1'b1, 1'b1, 1'b1);
        edge1();
        sel = 2'b00; #1;
        chk_data("sv_after", 8'hA5);
        chk_flags("sv_after", 1'b0, 1'b0, 1'b0);

        // 5: request held high -> ignored while busy, restarts at N+3
        save_req = 1'b1; next_pc = 8'h50; ccr = 4'b0011;
        edge1();
        next_pc = 8'h60; ccr = 4'b1100; #1;
        chk_data("b2b_a1", 8'h50);
        chk_flags("b2b_a1", 1'b1, 1'b1, 1'b0);
        edge1();
        chk_data("b2b_a2", 8'h03);
        chk_flags("b2b_a2", 1'b1, 1'b1, 1'b1);
        edge1();
        chk_data("b2b_idle", 8'hA5);
        chk_flags("b2b_idle", 1'b0, 1'b0, 1'b0);
        edge1();
        chk_data("b2b_b1", 8'h60);
        chk_flags("b2b_b1", 1'b1, 1'b1, 1'b0);
        save_req = 1'b0;
        edge1();
        chk_data("b2b_b2", 8'h0C);
        chk_flags("b2b_b2", 1'b1, 1'b1, 1'b1);
        edge1();
        chk_flags("b2b_end", 1'b0, 1'b0, 1'b0);
        edge1();
        chk_flags("b2b_quiet", 1'b0, 1'b0, 1'b0);

        // 6: reset during SAVE_PC abandons the CCR beat
        save_req = 1'b1; next_pc = 8'h77; ccr = 4'b1111;
        edge1();
        save_req = 1'b0; rst = 1'b1; #1;
        chk_data("ab_beat1", 8'h77);
        chk1("ab_beat1_we", save_we, 1'b1);
        edge1();
        rst = 1'b0; rb = 8'h5A; #1;
        chk_data("ab_rb", 8'h5A);
        chk_flags("ab_idle", 1'b0, 1'b0, 1'b0);
        sel = 2'b10; hist_idx = 1'b1; #1;
        chk_data("ab_hist1", 8'h00);
        edge1();
        chk_flags("ab_quiet", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
